// File: rtl/seg7_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg7_scan_mux                                              |
// | Description : Time-multiplexed 7-segment driver for a multi-digit BCD    |
// |               word. One shared active-low segment bus, one-hot digit     |
// |               enables, a blanking gap before every digit, and a          |
// |               double-buffered input so new values only take effect at    |
// |               frame boundaries.                                          |
// | Optional    : LEADING_ZERO_BLANK_EN - when defined, leading zero digits  |
// |               (all except digit 0) are blanked; decimal points are still |
// |               shown.                                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   in_valid    in   in_bcd / in_dp valid
//   in_ready    out  pending buffer empty; transfer on in_valid & in_ready
//   in_bcd      in   packed BCD digits, digit k at [4k+3:4k], digit 0 rightmost
//   in_dp       in   decimal point per digit, 1 = lit
//   seg_out     out  segments a..g on [6:0], active-low
//   dp_out      out  decimal point, active-low
//   dig_en      out  digit enable, one-hot or zero, active-high
//   frame_done  out  one-cycle pulse at the end of each full scan frame

module seg7_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_CNT   = 100,
  parameter int BLANK_CNT  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_bcd,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  // Timer only ever holds 0 .. max(SCAN_CNT, BLANK_CNT)-1.
  localparam int c_TMAX = (SCAN_CNT > BLANK_CNT) ? SCAN_CNT : BLANK_CNT;
  localparam int c_TW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
  localparam int c_IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [c_TW-1:0] c_SCAN_LAST  = c_TW'(SCAN_CNT - 1);
  localparam logic [c_TW-1:0] c_BLANK_LAST = c_TW'((BLANK_CNT > 0) ? (BLANK_CNT - 1) : 0);
  localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(NUM_DIGITS - 1);
  localparam logic [c_TW-1:0] c_T_ONE      = c_TW'(1);
  localparam logic [c_IW-1:0] c_I_ONE      = c_IW'(1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Scan state
  state_t                  state_q, state_d;
  logic [c_IW-1:0]         idx_q, idx_d;
  logic [c_TW-1:0]         timer_q, timer_d;
  logic                    w_boundary;

  // Double buffer
  logic [4*NUM_DIGITS-1:0] act_bcd_q, act_bcd_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_full_q, pend_full_d;

  // Registered outputs
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    frame_done_q;

  // Digit selection for the upcoming display state
  logic [3:0]              w_digit;
  logic                    w_dp_sel;
  logic                    w_lz_sel;
  logic [NUM_DIGITS-1:0]   w_lz_vec;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // ------------------------------------------------------------------
  // Scan sequencer: BLANK (BLANK_CNT cycles) then SHOW (SCAN_CNT cycles)
  // per digit. With BLANK_CNT = 0 the SHOW states run back-to-back.
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    w_boundary = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if ((BLANK_CNT == 0) || (timer_q == c_BLANK_LAST)) begin
          state_d = ST_SHOW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + c_T_ONE;
        end
      end
      ST_SHOW: begin
        if (timer_q == c_SCAN_LAST) begin
          timer_d = '0;
          state_d = (BLANK_CNT == 0) ? ST_SHOW : ST_BLANK;
          if (idx_q == c_IDX_LAST) begin
            idx_d      = '0;
            w_boundary = 1'b1;
          end else begin
            idx_d = idx_q + c_I_ONE;
          end
        end else begin
          timer_d = timer_q + c_T_ONE;
        end
      end
      default: begin
        state_d = ST_BLANK;
        idx_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Buffers. Transfer and capture are mutually exclusive: transfer needs
  // pending full, capture needs it empty. A capture on a boundary edge with
  // pending empty simply waits for the next boundary.
  // ------------------------------------------------------------------
  always_comb begin
    act_bcd_d   = act_bcd_q;
    act_dp_d    = act_dp_q;
    pend_bcd_d  = pend_bcd_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (w_boundary && pend_full_q) begin
      act_bcd_d   = pend_bcd_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end else if (in_valid && !pend_full_q) begin
      pend_bcd_d  = in_bcd;
      pend_dp_d   = in_dp;
      pend_full_d = 1'b1;
    end
  end

  // Leading-zero flags are taken from the next active buffer so the first
  // digit of a new frame already reflects the freshly transferred value.
`ifdef LEADING_ZERO_BLANK_EN
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
    if (k == 0) begin : g_lsd
      assign w_lz_vec[k] = 1'b0;
    end else begin : g_upper
      assign w_lz_vec[k] = ~|act_bcd_d[4*NUM_DIGITS-1:4*k];
    end
  end
`else
  assign w_lz_vec = '0;
`endif

  always_comb begin
    w_digit  = 4'hF;
    w_dp_sel = 1'b0;
    w_lz_sel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == c_IW'(k)) begin
        w_digit  = act_bcd_d[4*k +: 4];
        w_dp_sel = act_dp_d[k];
        w_lz_sel = w_lz_vec[k];
      end
    end
  end

  // Outputs are computed from the next state so enable and segments switch
  // on the same edge: an enabled digit never sees a neighbour's pattern.
  always_comb begin
    seg_d    = 7'b1111111;
    dp_d     = 1'b1;
    dig_en_d = '0;
    if (state_d == ST_SHOW) begin
      dig_en_d = NUM_DIGITS'(1) << idx_d;
      seg_d    = w_lz_sel ? 7'b1111111 : decode(w_digit);
      dp_d     = ~w_dp_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      timer_q      <= '0;
      act_bcd_q    <= {NUM_DIGITS{4'hF}};
      act_dp_q     <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      act_bcd_q    <= act_bcd_d;
      act_dp_q     <= act_dp_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= w_boundary;
    end
  end

  assign in_ready   = ~pend_full_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seg7_scan_mux                                           |
// | Description : Self-checking bench for seg7_scan_mux. Loaded words are    |
// |               queued as expected frame contents; a negedge monitor pops  |
// |               one per frame boundary and checks every display cycle.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_seg7_scan_mux;

  localparam int ND    = 4;
  localparam int SCAN  = 100;
  localparam int BLANK = 4;
  localparam int SLOT  = BLANK + SCAN;
  localparam int FRAME = ND * SLOT;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_bcd   = 16'h0;
  logic [3:0]    in_dp    = 4'h0;
  logic          in_ready;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [3:0]    dig_en;
  logic          frame_done;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
  } disp_t;

  disp_t       sb[$];
  disp_t       cur;
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned edge_n;

  seg7_scan_mux #(
    .NUM_DIGITS (ND),
    .SCAN_CNT   (SCAN),
    .BLANK_CNT  (BLANK)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bcd     (in_bcd),
    .in_dp      (in_dp),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Edges since reset release; edge 1 starts the first frame.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
          7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    return t[v];
  endfunction

  function automatic logic [6:0] exp_seg(input disp_t d, input int k);
    logic [15:0] w;
    logic [3:0]  dig;
    w   = d.bcd;
    dig = w[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && (w >> (4*k)) == 16'h0) return 7'b1111111;
`endif
    return dec(dig);
  endfunction

  // Per-cycle display monitor. In-frame position p: digit p/SLOT, blank
  // while p%SLOT < BLANK, lit otherwise; p == 0 (after edge 0) is the
  // boundary edge where the next queued word becomes visible.
  always @(negedge clk) begin
    int        p, q, d;
    logic [3:0] e_en;
    logic [6:0] e_seg;
    logic       e_dp;
    if (!reset_n) begin
      sb.delete();
      cur.bcd = 16'hFFFF;
      cur.dp  = 4'h0;
      check("rst_dig_en", 32'(dig_en), 32'h0);
      check("rst_seg", 32'(seg_out), 32'h7F);
      check("rst_dp", 32'(dp_out), 32'h1);
      check("rst_frame_done", 32'(frame_done), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h1);
    end else begin
      p = int'(edge_n % FRAME);
      q = p % SLOT;
      d = p / SLOT;
      if (p == 0 && edge_n != 0 && sb.size() > 0) cur = sb.pop_front();
      check("frame_done", 32'(frame_done), 32'(p == 0 && edge_n != 0));
      e_en  = 4'h0;
      e_seg = 7'b1111111;
      e_dp  = 1'b1;
      if (q >= BLANK) begin
        e_en  = 4'b0001 << d;
        e_seg = exp_seg(cur, d);
        e_dp  = ~cur.dp[d];
      end
      check("dig_en", 32'(dig_en), 32'(e_en));
      check("seg_out", 32'(seg_out), 32'(e_seg));
      check("dp_out", 32'(dp_out), 32'(e_dp));
    end
  end

  task automatic wait_edge(input int unsigned n);
    while (edge_n < n) @(negedge clk);
  endtask

  // Drive a word (at a negedge) and hold valid until it is taken. acc
  // returns the edge number that accepted it.
  task automatic load(input logic [15:0] b, input logic [3:0] dp, output int acc);
    disp_t e;
    bit    got;
    got   = 1'b0;
    acc   = -1;
    e.bcd = b;
    e.dp  = dp;
    in_valid = 1'b1;
    in_bcd   = b;
    in_dp    = dp;
    sb.push_back(e);
    for (int i = 0; i < 2000; i++) begin
      if (in_ready) begin
        @(negedge clk);
        acc = int'(edge_n);
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_bcd   = 16'hDEAD;
    in_dp    = 4'hF;
    check("load_accepted", 32'(got), 32'h1);
  endtask

  initial begin
    int acc;

    // Reset held 10 cycles, released on a negedge
    reset_n = 1'b0;
    repeat (10) @(negedge clk);
    check("ready_in_reset", 32'(in_ready), 32'h1);
    reset_n = 1'b1;

    // Frame 0 blank; load 1234 mid-frame, visible in frame 1
    wait_edge(100);
    load(16'h1234, 4'b0100, acc);
    check("acc_1234", 32'(acc), 32'd101);
    check("ready_low_after_load", 32'(in_ready), 32'h0);
    wait_edge(FRAME - 1);
    check("ready_low_pre_boundary", 32'(in_ready), 32'h0);
    wait_edge(FRAME);
    check("ready_high_post_boundary", 32'(in_ready), 32'h1);

    // Back-pressure: 2222 stalls behind 1111, taken one edge after boundary
    wait_edge(FRAME + 50);
    load(16'h1111, 4'b0001, acc);
    check("acc_1111", 32'(acc), 32'(FRAME + 51));
    load(16'h2222, 4'b1000, acc);
    check("acc_2222", 32'(acc), 32'(2*FRAME + 1));

    // Invalid codes blank the segments while scanning continues
    wait_edge(3*FRAME + 20);
    load(16'hABCF, 4'b1010, acc);
    check("acc_abcf", 32'(acc), 32'(3*FRAME + 21));

    // Zero-heavy words (leading-zero behaviour depends on build)
    wait_edge(4*FRAME + 100);
    load(16'h0070, 4'b0000, acc);
    wait_edge(5*FRAME + 100);
    load(16'h0000, 4'b0010, acc);

    // Reset while digit 2 is lit and pending is full
    wait_edge(6*FRAME + 100);
    load(16'h5678, 4'b1111, acc);
    check("ready_low_pending_full", 32'(in_ready), 32'h0);
    wait_edge(6*FRAME + 262);
    check("pre_reset_digit2", 32'(dig_en), 32'h4);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_dig_en", 32'(dig_en), 32'h0);
    check("async_rst_seg", 32'(seg_out), 32'h7F);
    check("async_rst_dp", 32'(dp_out), 32'h1);
    check("async_rst_ready", 32'(in_ready), 32'h1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Pending 5678 was lost: a full frame of blanks and its boundary pulse
    wait_edge(FRAME + 5);
    check("ready_after_reset_frame", 32'(in_ready), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
